// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and helpers for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam logic [KP_COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } kp_state_e;

  // Index of the low bit in a one-hot-zero column sample.
  function automatic logic [1:0] zero_idx(input logic [KP_COLS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < KP_COLS; i++)
      if (!v[i]) idx = i[1:0];
    return idx;
  endfunction

  function automatic logic single_zero(input logic [KP_COLS-1:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [KP_ROWS-1:0] row_strobe(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the decoded key report.
interface keypad_scan_if;
  import keypad_pkg::*;
  logic [KP_COLS-1:0] col_in;
  logic [KP_ROWS-1:0] row_out;
  logic [3:0]         key_code;
  logic               key_valid;
  logic               key_held;

  modport master (input col_in, output row_out, key_code, key_valid, key_held);
  modport slave  (output col_in, input row_out, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_tick.sv
// Free-running prescaler: one-clk tick every 2^SCAN_DIV cycles.
module scan_tick #(
  parameter int SCAN_DIV = 12
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  logic [SCAN_DIV-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + SCAN_DIV'(1);

  assign tick_o = &cnt_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with press/release debounce and one-clk key_valid.
// Define KEYPAD_REPEAT_EN to add auto-repeat every REPEAT_SCANS ticks while held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic         clk,
  input  logic         rst,
  keypad_scan_if.master kp
);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  logic [KP_COLS-1:0] s1_q, sc_q, cap_col_q;
  logic [KP_ROWS-1:0] row_out_q;
  logic [1:0]         row_idx_q, row_nxt_d;
  logic [3:0]         deb_cnt_q, deb_inc_d, rel_cnt_d, key_code_q;
  logic               key_valid_q, key_held_q, tick;
  kp_state_e          state_q;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick_o(tick));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= COL_IDLE;
      sc_q <= COL_IDLE;
    end else begin
      s1_q <= kp.col_in;
      sc_q <= s1_q;
    end

  assign row_nxt_d = row_idx_q + 2'd1;
  assign deb_inc_d = deb_cnt_q + 4'd1;
  // Any low column during release restarts the release count.
  assign rel_cnt_d = (sc_q == COL_IDLE) ? deb_inc_d : 4'd0;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_q;
`else
  wire unused_repeat = |REPEAT_SCANS;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_SCAN;
      row_idx_q   <= 2'd0;
      row_out_q   <= row_strobe(2'd0);
      cap_col_q   <= COL_IDLE;
      deb_cnt_q   <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_SCAN:
            if (single_zero(sc_q)) begin
              cap_col_q <= sc_q;
              deb_cnt_q <= 4'd1;
              state_q   <= ST_DEBOUNCE;
            end else begin
              row_idx_q <= row_nxt_d;
              row_out_q <= row_strobe(row_nxt_d);
            end
          ST_DEBOUNCE:
            if (sc_q == cap_col_q) begin
              if (deb_inc_d == DEB_N) begin
                key_code_q  <= {row_idx_q, zero_idx(cap_col_q)};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                deb_cnt_q   <= 4'd0;
                state_q     <= ST_PRESSED;
              end else begin
                deb_cnt_q <= deb_inc_d;
              end
            end else begin
              // Bounce: stay on this row so it is re-sampled next tick.
              deb_cnt_q <= 4'd0;
              state_q   <= ST_SCAN;
            end
          ST_PRESSED:
            if (rel_cnt_d == DEB_N) begin
              key_held_q <= 1'b0;
              deb_cnt_q  <= 4'd0;
              row_idx_q  <= row_nxt_d;
              row_out_q  <= row_strobe(row_nxt_d);
              state_q    <= ST_SCAN;
            end else begin
              deb_cnt_q <= rel_cnt_d;
            end
          default: state_q <= ST_SCAN;
        endcase
`ifdef KEYPAD_REPEAT_EN
        if (state_q == ST_PRESSED && sc_q == cap_col_q) begin
          if (rep_q + REP_W'(1) == REP_W'(REPEAT_SCANS)) begin
            rep_q       <= '0;
            key_valid_q <= 1'b1;
          end else begin
            rep_q <= rep_q + REP_W'(1);
          end
        end else begin
          rep_q <= '0;
        end
`endif
      end
    end

  assign kp.row_out   = row_out_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
endmodule
